// File: rtl/mem_write_arbiter_if.sv
// rtl/mem_write_arbiter_if.sv - LSU store request and memory write channel bundle
interface mem_write_arbiter_if #(
    parameter int NUM_LSUS  = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic [NUM_LSUS-1:0]           lsu_write_valid;
    logic [NUM_LSUS*ADDR_BITS-1:0] lsu_write_address;
    logic [NUM_LSUS*DATA_BITS-1:0] lsu_write_data;
    logic [NUM_LSUS-1:0]           lsu_write_ready;
    logic                          mem_write_valid;
    logic [ADDR_BITS-1:0]          mem_write_address;
    logic [DATA_BITS-1:0]          mem_write_data;
    logic                          mem_write_ready;

    modport slave (
        input  lsu_write_valid, lsu_write_address, lsu_write_data, mem_write_ready,
        output lsu_write_ready, mem_write_valid, mem_write_address, mem_write_data
    );

    modport master (
        output lsu_write_valid, lsu_write_address, lsu_write_data, mem_write_ready,
        input  lsu_write_ready, mem_write_valid, mem_write_address, mem_write_data
    );
endinterface

// File: rtl/mem_write_arbiter.sv
// rtl/mem_write_arbiter.sv - round-robin arbiter sharing one memory write port among LSUs
module mem_write_arbiter #(
    parameter int NUM_LSUS  = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    mem_write_arbiter_if.slave          bus,
    output logic [$clog2(NUM_LSUS)-1:0] grant_id,
    output logic                        busy,
    output logic [15:0]                 write_count
);
    localparam int ID_BITS = $clog2(NUM_LSUS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_ACK      = 2'd2
    } state_t;

    state_t                 r_state,     w_state_next;
    logic [ID_BITS-1:0]     r_rr_ptr,    w_rr_ptr_next;
    logic [ID_BITS-1:0]     r_grant_id,  w_grant_id_next;
    logic [NUM_LSUS-1:0]    r_ready,     w_ready_next;
    logic                   r_mem_valid, w_mem_valid_next;
    logic [ADDR_BITS-1:0]   r_mem_addr,  w_mem_addr_next;
    logic [DATA_BITS-1:0]   r_mem_data,  w_mem_data_next;
    logic [15:0]            r_count,     w_count_next;
    logic [ID_BITS-1:0]     w_winner;
    logic                   w_any_valid;

    // Descending scan so the lowest offset from the pointer wins.
    always_comb begin
        int idx;
        w_winner    = r_rr_ptr;
        w_any_valid = |bus.lsu_write_valid;
        for (int k = NUM_LSUS - 1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_LSUS) idx = idx - NUM_LSUS;
            if (bus.lsu_write_valid[idx]) w_winner = ID_BITS'(idx);
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_rr_ptr_next    = r_rr_ptr;
        w_grant_id_next  = r_grant_id;
        w_ready_next     = r_ready;
        w_mem_valid_next = r_mem_valid;
        w_mem_addr_next  = r_mem_addr;
        w_mem_data_next  = r_mem_data;
        w_count_next     = r_count;
        case (r_state)
            S_IDLE: begin
                if (w_any_valid) begin
                    w_grant_id_next  = w_winner;
                    w_mem_addr_next  = bus.lsu_write_address[w_winner*ADDR_BITS +: ADDR_BITS];
                    w_mem_data_next  = bus.lsu_write_data[w_winner*DATA_BITS +: DATA_BITS];
                    w_mem_valid_next = 1'b1;
                    w_state_next     = S_WAIT_MEM;
                end
            end
            S_WAIT_MEM: begin
                if (bus.mem_write_ready) begin
                    w_mem_valid_next             = 1'b0;
                    w_ready_next                 = '0;
                    w_ready_next[r_grant_id]     = 1'b1;
                    w_count_next                 = r_count + 16'd1;
                    w_state_next                 = S_ACK;
                end
            end
            S_ACK: begin
                w_ready_next  = '0;
                w_rr_ptr_next = (r_grant_id == ID_BITS'(NUM_LSUS - 1)) ? '0 : r_grant_id + 1'b1;
                w_state_next  = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_ready     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_rr_ptr    <= w_rr_ptr_next;
            r_grant_id  <= w_grant_id_next;
            r_ready     <= w_ready_next;
            r_mem_valid <= w_mem_valid_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_data  <= w_mem_data_next;
            r_count     <= w_count_next;
        end
    end

    assign bus.lsu_write_ready   = r_ready;
    assign bus.mem_write_valid   = r_mem_valid;
    assign bus.mem_write_address = r_mem_addr;
    assign bus.mem_write_data    = r_mem_data;
    assign grant_id              = r_grant_id;
    assign busy                  = (r_state != S_IDLE);
    assign write_count           = r_count;
endmodule

// File: tb/tb_mem_write_arbiter.sv
// tb/tb_mem_write_arbiter.sv - self-checking bench for mem_write_arbiter
module tb_mem_write_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] write_count;

    int checks = 0;
    int errors = 0;

    mem_write_arbiter_if #(.NUM_LSUS(N), .ADDR_BITS(8), .DATA_BITS(8)) bus_if ();

    mem_write_arbiter #(.NUM_LSUS(N), .ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if.slave),
        .grant_id    (grant_id),
        .busy        (busy),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one write in flight, then one acknowledge cycle.
    logic [3:0] m_ready    = '0;
    logic       m_inflight = 1'b0;
    logic       m_ack      = 1'b0;
    int         m_ptr      = 0;
    int         m_gid      = 0;
    logic [7:0] m_addr     = '0;
    logic [7:0] m_data     = '0;
    int         m_count    = 0;
    bit         started    = 1'b0;

    always @(posedge clk) begin : model
        int  w;
        bit  found;
        if (reset) begin
            m_ready <= '0; m_inflight <= 1'b0; m_ack <= 1'b0; m_ptr <= 0; m_gid <= 0;
            m_addr <= '0; m_data <= '0; m_count <= 0; started <= 1'b1;
        end else if (m_inflight) begin
            if (bus_if.mem_write_ready) begin
                m_inflight <= 1'b0;
                m_ack      <= 1'b1;
                m_ready    <= 4'b0001 << m_gid;
                m_count    <= (m_count + 1) % 65536;
            end
        end else if (m_ack) begin
            m_ack   <= 1'b0;
            m_ready <= '0;
            m_ptr   <= (m_gid + 1) % N;
        end else begin
            found = 1'b0;
            w     = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && bus_if.lsu_write_valid[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    w     = (m_ptr + k) % N;
                end
            end
            if (found) begin
                m_gid      <= w;
                m_addr     <= bus_if.lsu_write_address[w*8 +: 8];
                m_data     <= bus_if.lsu_write_data[w*8 +: 8];
                m_inflight <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cmp_lsu_ready", 32'(bus_if.lsu_write_ready), 32'(m_ready));
            check("cmp_mem_valid", 32'(bus_if.mem_write_valid), 32'(m_inflight));
            check("cmp_busy",      32'(busy), 32'(m_inflight | m_ack));
            check("cmp_count",     32'(write_count), 32'(m_count));
            if (m_inflight) begin
                check("cmp_grant", 32'(grant_id), 32'(m_gid));
                check("cmp_addr",  32'(bus_if.mem_write_address), 32'(m_addr));
                check("cmp_data",  32'(bus_if.mem_write_data), 32'(m_data));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    int seq[5];
    int at_cycle[5];
    int n_grants;
    bit prev_valid;

    initial begin
        bus_if.lsu_write_valid   = '0;
        bus_if.lsu_write_address = '0;
        bus_if.lsu_write_data    = '0;
        bus_if.mem_write_ready   = 1'b0;
        do_reset();

        check("reset_count", 32'(write_count), 0);
        check("reset_valid", 32'(bus_if.mem_write_valid), 0);
        check("reset_busy",  32'(busy), 0);
        check("reset_grant", 32'(grant_id), 0);
        check("reset_ready", 32'(bus_if.lsu_write_ready), 0);

        // Single write from LSU2
        bus_if.lsu_write_valid   = 4'b0100;
        bus_if.lsu_write_address = 32'h003C_0000;
        bus_if.lsu_write_data    = 32'h00A5_0000;
        step();
        check("t1_valid", 32'(bus_if.mem_write_valid), 1);
        check("t1_addr",  32'(bus_if.mem_write_address), 'h3C);
        check("t1_data",  32'(bus_if.mem_write_data), 'hA5);
        check("t1_grant", 32'(grant_id), 2);
        bus_if.mem_write_ready = 1'b1;
        step();
        check("t1_ready", 32'(bus_if.lsu_write_ready), 'b0100);
        check("t1_valid_drop", 32'(bus_if.mem_write_valid), 0);
        check("t1_count", 32'(write_count), 1);
        bus_if.lsu_write_valid = '0;
        bus_if.mem_write_ready = 1'b0;
        step();
        check("t1_ready_off", 32'(bus_if.lsu_write_ready), 0);

        // Spurious memory ready while idle and during the acknowledge cycle
        bus_if.mem_write_ready = 1'b1;
        repeat (3) step();
        check("t6_idle_count", 32'(write_count), 1);
        check("t6_idle_busy",  32'(busy), 0);
        bus_if.lsu_write_valid = 4'b0001;
        bus_if.lsu_write_data  = 32'h0000_0011;
        step();
        step();
        check("t6_ready", 32'(bus_if.lsu_write_ready), 'b0001);
        bus_if.lsu_write_valid = '0;
        step();
        step();
        step();
        check("t6_count", 32'(write_count), 2);
        check("t6_ready_off", 32'(bus_if.lsu_write_ready), 0);
        bus_if.mem_write_ready = 1'b0;

        // Memory stall with the source address changing underneath
        bus_if.lsu_write_valid   = 4'b0010;
        bus_if.lsu_write_address = 32'h0000_5500;
        bus_if.lsu_write_data    = 32'h0000_6600;
        step();
        bus_if.lsu_write_address = 32'h0000_7700;
        for (int i = 0; i < 10; i++) begin
            check("t3_valid", 32'(bus_if.mem_write_valid), 1);
            check("t3_addr",  32'(bus_if.mem_write_address), 'h55);
            check("t3_data",  32'(bus_if.mem_write_data), 'h66);
            check("t3_ready", 32'(bus_if.lsu_write_ready), 0);
            step();
        end
        bus_if.mem_write_ready = 1'b1;
        step();
        check("t3_ack", 32'(bus_if.lsu_write_ready), 'b0010);
        check("t3_count", 32'(write_count), 3);
        bus_if.lsu_write_valid = '0;
        bus_if.mem_write_ready = 1'b0;
        step();

        // Pointer now at 2: LSU3 beats LSU0
        bus_if.lsu_write_valid = 4'b1001;
        step();
        check("t4_grant", 32'(grant_id), 3);
        bus_if.mem_write_ready = 1'b1;
        step();
        check("t4_ready", 32'(bus_if.lsu_write_ready), 'b1000);
        bus_if.lsu_write_valid = 4'b0001;
        bus_if.mem_write_ready = 1'b0;
        step();
        step();
        check("t4_grant_next", 32'(grant_id), 0);
        bus_if.mem_write_ready = 1'b1;
        step();
        bus_if.lsu_write_valid = '0;
        bus_if.mem_write_ready = 1'b0;
        step();

        // Reset while waiting on memory with LSU1 granted
        bus_if.lsu_write_valid = 4'b0010;
        step();
        check("t5_grant", 32'(grant_id), 1);
        reset = 1'b1;
        step();
        check("t5_valid", 32'(bus_if.mem_write_valid), 0);
        check("t5_ready", 32'(bus_if.lsu_write_ready), 0);
        check("t5_count", 32'(write_count), 0);
        check("t5_busy",  32'(busy), 0);
        check("t5_addr",  32'(bus_if.mem_write_address), 0);
        reset = 1'b0;
        bus_if.lsu_write_valid = '0;
        step();
        check("t5_after", 32'(bus_if.lsu_write_ready), 0);

        // All four requesting continuously
        do_reset();
        bus_if.lsu_write_valid   = 4'b1111;
        bus_if.lsu_write_address = 32'h4030_2010;
        bus_if.lsu_write_data    = 32'hD0C0_B0A0;
        bus_if.mem_write_ready   = 1'b1;
        n_grants   = 0;
        prev_valid = 1'b0;
        for (int c = 0; c < 40 && n_grants < 5; c++) begin
            step();
            if (bus_if.mem_write_valid && !prev_valid) begin
                seq[n_grants]      = int'(grant_id);
                at_cycle[n_grants] = c;
                n_grants++;
            end
            prev_valid = bus_if.mem_write_valid;
        end
        check("t2_grant_total", 32'(n_grants), 5);
        if (n_grants == 5) begin
            check("t2_seq0", 32'(seq[0]), 0);
            check("t2_seq1", 32'(seq[1]), 1);
            check("t2_seq2", 32'(seq[2]), 2);
            check("t2_seq3", 32'(seq[3]), 3);
            check("t2_seq4", 32'(seq[4]), 0);
            for (int i = 1; i < 5; i++)
                check("t2_spacing", 32'(at_cycle[i] - at_cycle[i-1]), 3);
        end
        check("t2_count", 32'(write_count), 4);
        bus_if.lsu_write_valid = '0;
        bus_if.mem_write_ready = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
